// File: rtl/cover_pkg.sv
// cover_pkg: shared mode encodings, scanner FSM states and pipeline flush depth for cover_scan.
package cover_pkg;

    localparam logic [1:0] MODE_UNION = 2'd0;
    localparam logic [1:0] MODE_AND   = 2'd1;
    localparam logic [1:0] MODE_XOR1  = 2'd2;

    localparam int FLUSH_DEPTH = 2;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

endpackage

// File: rtl/cover_dist.sv
// cover_dist: one circle channel; registers |d|^2 terms and r^2, then compares their sum against r^2.
module cover_dist #(
    parameter int COORD_W = 3,
    parameter int RAD_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W:0]   x,
    input  logic [COORD_W:0]   y,
    input  logic [COORD_W:0]   cx,
    input  logic [COORD_W:0]   cy,
    input  logic [RAD_W-1:0]   r,
    input  logic               en,
    output logic               hit
);

    localparam int QW = 2*COORD_W + 2;
    localparam int SW = QW + 1;
    localparam int RW = 2*RAD_W;
    localparam int CW = (SW > RW) ? SW : RW;

    logic [COORD_W:0] dx, dy;
    logic [QW-1:0]    dxw, dyw, sx, sy;
    logic [RW-1:0]    r2;
    logic             en_q;

    assign dx  = (x >= cx) ? x - cx : cx - x;
    assign dy  = (y >= cy) ? y - cy : cy - y;
    assign dxw = QW'(dx);
    assign dyw = QW'(dy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx   <= '0;
            sy   <= '0;
            r2   <= '0;
            en_q <= 1'b0;
        end else begin
            sx   <= dxw * dxw;
            sy   <= dyw * dyw;
            r2   <= RW'(r) * RW'(r);
            en_q <= en;
        end
    end

    // Both sides widened so neither the sum nor r^2 can wrap.
    assign hit = en_q && (CW'(sx) + CW'(sy) <= CW'(r2));

endmodule

// File: rtl/cover_scan.sv
// cover_scan: raster-scans the grid, combines NUM_SET circle hits and streams one coverage bit per point.
// Define COVER_COUNT_EN to add the cover_cnt covered-point counter.
module cover_scan import cover_pkg::*; #(
    parameter int COORD_W = 3,
    parameter int NUM_SET = 2,
    parameter int RAD_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [NUM_SET-1:0]           set_en,
    input  logic [NUM_SET*(COORD_W+1)-1:0] center_x,
    input  logic [NUM_SET*(COORD_W+1)-1:0] center_y,
    input  logic [NUM_SET*RAD_W-1:0]     radius,
    output logic                         busy,
    output logic                         table_we,
    output logic [2*COORD_W-1:0]         table_addr,
    output logic                         table_data,
    output logic                         done
`ifdef COVER_COUNT_EN
    ,
    output logic [2*COORD_W:0]           cover_cnt
`endif
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2*COORD_W;
    localparam logic [PW-1:0] LAST = {PW{1'b1}};
    localparam logic [DW-1:0] ONE  = DW'(1);

    state_t state, nxt;
    logic [PW-1:0]              cnt, a1;
    logic [1:0]                 fcnt;
    logic [1:0]                 mode_q;
    logic [NUM_SET-1:0]         en_q, hits;
    logic [NUM_SET*DW-1:0]      cx_q, cy_q;
    logic [NUM_SET*RAD_W-1:0]   r_q;
    logic [DW-1:0]              x, y;
    logic                       v1, l1, comb_hit, accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt    = state;
        busy   = state != S_IDLE;
        accept = 1'b0;
        case (state)
            S_IDLE: begin
                accept = start;
                nxt    = start ? S_SCAN : S_IDLE;
            end
            S_SCAN:  nxt = (cnt == LAST) ? S_FLUSH : S_SCAN;
            S_FLUSH: nxt = (fcnt == 2'(FLUSH_DEPTH - 1)) ? S_IDLE : S_FLUSH;
            default: nxt = S_IDLE;
        endcase
    end

    // Grid coordinates are 1-based; the point counter is {y-1, x-1}.
    assign x = {1'b0, cnt[COORD_W-1:0]} + ONE;
    assign y = {1'b0, cnt[PW-1:COORD_W]} + ONE;

    for (genvar i = 0; i < NUM_SET; i++) begin : g_ch
        cover_dist #(.COORD_W(COORD_W), .RAD_W(RAD_W)) u_dist (
            .clk   (clk),
            .rst_n (rst_n),
            .x     (x),
            .y     (y),
            .cx    (cx_q[i*DW +: DW]),
            .cy    (cy_q[i*DW +: DW]),
            .r     (r_q[i*RAD_W +: RAD_W]),
            .en    (en_q[i]),
            .hit   (hits[i])
        );
    end

    always_comb begin
        comb_hit = (mode_q == MODE_AND)  ? (|en_q && &(hits | ~en_q)) :
                   (mode_q == MODE_XOR1) ? ($countones(hits) == 1) :
                                           |hits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            fcnt       <= '0;
            mode_q     <= '0;
            en_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            r_q        <= '0;
            v1         <= 1'b0;
            l1         <= 1'b0;
            a1         <= '0;
            table_we   <= 1'b0;
            table_addr <= '0;
            table_data <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (accept) begin
                mode_q <= mode;
                en_q   <= set_en;
                cx_q   <= center_x;
                cy_q   <= center_y;
                r_q    <= radius;
                cnt    <= '0;
            end else if (state == S_SCAN) begin
                cnt <= cnt + PW'(1);
            end
            fcnt       <= (state == S_FLUSH) ? fcnt + 2'd1 : 2'd0;
            v1         <= state == S_SCAN;
            l1         <= state == S_SCAN && cnt == LAST;
            a1         <= cnt;
            table_we   <= v1;
            table_addr <= a1;
            table_data <= v1 && comb_hit;
            done       <= l1;
        end
    end

`ifdef COVER_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     cover_cnt <= '0;
        else if (accept)                cover_cnt <= '0;
        else if (table_we && table_data) cover_cnt <= cover_cnt + (PW+1)'(1);
    end
`endif

endmodule

// File: tb/tb_cover_scan.sv
// tb_cover_scan: table-driven and randomized scans of cover_scan checked against a point-by-point geometric model.
module tb_cover_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [1:0] set_en = '0;
    logic [7:0] center_x = '0, center_y = '0, radius = '0;
    logic       busy, table_we, table_data, done;
    logic [5:0] table_addr;
`ifdef COVER_COUNT_EN
    logic [6:0] cover_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] en;
        logic [3:0] cx0, cy0, r0, cx1, cy1, r1;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    cover_scan dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .set_en     (set_en),
        .center_x   (center_x),
        .center_y   (center_y),
        .radius     (radius),
        .busy       (busy),
        .table_we   (table_we),
        .table_addr (table_addr),
        .table_data (table_data),
        .done       (done)
`ifdef COVER_COUNT_EN
        ,
        .cover_cnt  (cover_cnt)
`endif
    );

    always #5 clk = ~clk;

    task check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [1:0] e,
                                input logic [3:0] cx0, input logic [3:0] cy0, input logic [3:0] r0,
                                input logic [3:0] cx1, input logic [3:0] cy1, input logic [3:0] r1,
                                input int exp_cnt);
        vec_t v;
        v.mode = m; v.en = e;
        v.cx0 = cx0; v.cy0 = cy0; v.r0 = r0;
        v.cx1 = cx1; v.cy1 = cy1; v.r1 = r1;
        v.exp_cnt = exp_cnt;
        return v;
    endfunction

    // Each grid point is tested against every enabled circle with integer geometry.
    function automatic logic [63:0] model(input vec_t v);
        logic [63:0] m = '0;
        int cx[2], cy[2], r[2];
        cx[0] = int'(v.cx0); cy[0] = int'(v.cy0); r[0] = int'(v.r0);
        cx[1] = int'(v.cx1); cy[1] = int'(v.cy1); r[1] = int'(v.r1);
        for (int p = 0; p < 64; p++) begin
            int x, y, n, ne;
            x = p % 8 + 1;
            y = p / 8 + 1;
            n = 0;
            ne = 0;
            for (int i = 0; i < 2; i++) begin
                if (v.en[i]) begin
                    ne++;
                    if ((x-cx[i])*(x-cx[i]) + (y-cy[i])*(y-cy[i]) <= r[i]*r[i]) n++;
                end
            end
            case (v.mode)
                2'd1:    m[p] = (ne > 0) && (n == ne);
                2'd2:    m[p] = (n == 1);
                default: m[p] = (n > 0);
            endcase
        end
        return m;
    endfunction

    task apply(input vec_t v);
        mode     = v.mode;
        set_en   = v.en;
        center_x = {v.cx1, v.cx0};
        center_y = {v.cy1, v.cy0};
        radius   = {v.r1, v.r0};
    endtask

    task run_scan(input string tag, input vec_t v, input bit restart);
        logic [63:0] got, exp;
        int bad_we, bad_busy, ndone, dcyc;
        vec_t alt;
        got = '0; bad_we = 0; bad_busy = 0; ndone = 0; dcyc = -1;
        exp = model(v);
        @(negedge clk);
        apply(v);
        start = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) begin
                alt = v;
                alt.cx0 = 4'($urandom_range(0, 15));
                alt.r1  = 4'($urandom_range(0, 15));
                alt.en  = ~v.en;
                apply(alt);
            end
            if (restart && c == 20) begin
                alt = v;
                alt.cx0 = v.cx0 ^ 4'd5;
                alt.cy1 = v.cy1 ^ 4'd3;
                alt.r0  = v.r0 ^ 4'd7;
                alt.mode = v.mode ^ 2'd1;
                apply(alt);
                start = 1'b1;
            end
            if (table_we !== (c >= 3 && c <= 66) || (table_we && table_addr !== 6'(c - 3))) bad_we++;
            if (busy !== (c <= 66)) bad_busy++;
            if (table_we) got[table_addr] = table_data;
            if (done) begin
                ndone++;
                dcyc = c;
            end
        end
        check({tag, " map"}, got, exp);
        check({tag, " write_timing_errs"}, 64'(bad_we), 64'd0);
        check({tag, " busy_errs"}, 64'(bad_busy), 64'd0);
        check({tag, " done_count"}, 64'(ndone), 64'd1);
        check({tag, " done_cycle"}, 64'(dcyc), 64'd66);
        if (v.exp_cnt >= 0) check({tag, " covered_points"}, 64'($countones(got)), 64'(v.exp_cnt));
`ifdef COVER_COUNT_EN
        check({tag, " cover_cnt"}, 64'(cover_cnt), 64'($countones(exp)));
`endif
    endtask

    initial begin
        int anyact;
        vecs.push_back(mk(2'd0, 2'b01, 4'd4, 4'd4, 4'd0, 4'd1, 4'd1, 4'd3, 1));
        vecs.push_back(mk(2'd0, 2'b01, 4'd4, 4'd4, 4'd1, 4'd1, 4'd1, 4'd3, 5));
        vecs.push_back(mk(2'd1, 2'b11, 4'd4, 4'd4, 4'd1, 4'd5, 4'd4, 4'd1, 2));
        vecs.push_back(mk(2'd2, 2'b11, 4'd4, 4'd4, 4'd1, 4'd5, 4'd4, 4'd1, 6));
        vecs.push_back(mk(2'd0, 2'b01, 4'd4, 4'd4, 4'd15, 4'd2, 4'd2, 4'd0, 64));
        vecs.push_back(mk(2'd1, 2'b00, 4'd4, 4'd4, 4'd15, 4'd5, 4'd5, 4'd15, 0));
        vecs.push_back(mk(2'd3, 2'b11, 4'd1, 4'd1, 4'd2, 4'd8, 4'd8, 4'd3, -1));
        vecs.push_back(mk(2'd0, 2'b10, 4'd0, 4'd0, 4'd9, 4'd9, 4'd9, 4'd2, -1));

        @(negedge clk);
        check("reset_outputs", {58'd0, busy, table_we, table_data, done, 2'd0} | 64'(table_addr), 64'd0);
`ifdef COVER_COUNT_EN
        check("reset_cover_cnt", 64'(cover_cnt), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("single_point_addr27", {63'd0, (model(vecs[0]) == (64'd1 << 27))}, 64'd1);

        for (int i = 0; i < vecs.size(); i++) run_scan($sformatf("vec%0d", i), vecs[i], 1'b0);

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v = mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 6)),
                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 6)), -1);
            run_scan($sformatf("rand%0d", i), v, 1'b0);
        end

        run_scan("restart_ignored", vecs[1], 1'b1);

        // Mid-scan reset: outputs clear without waiting for a clock edge.
        @(negedge clk);
        apply(vecs[1]);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {58'd0, busy, table_we, table_data, done, 2'd0} | 64'(table_addr), 64'd0);
`ifdef COVER_COUNT_EN
        check("async_reset_cover_cnt", 64'(cover_cnt), 64'd0);
`endif
        anyact = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy || table_we) anyact++;
        end
        check("no_activity_after_reset", 64'(anyact), 64'd0);
        run_scan("post_reset", vecs[2], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cover_scan.md
# cover_scan

Parametrised grid-coverage scanner, successor to the single-circle cover unit. After a `start` pulse it walks every point of a 2^COORD_W × 2^COORD_W grid in raster order and evaluates up to NUM_SET circles at each point. It combines the per-circle hits by a selectable mode and writes one coverage bit per point to the external coverage table. It sits between the set-cover controller FSM and the coverage table RAM.

## Interface
- COORD_W, 3, grid side = 2^COORD_W; grid coordinates are 1..2^COORD_W
- NUM_SET, 2, number of circle channels
- RAD_W, 4, radius width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  scan request; sampled only in IDLE
- mode  in  2  combine mode: 0 = union, 1 = intersection, 2 = exactly-one (XOR-one), 3 = union
- set_en  in  NUM_SET  per-circle enable
- center_x, center_y  in  NUM_SET*(COORD_W+1)  packed centres; channel i occupies bits [i*(COORD_W+1) +: COORD_W+1]
- radius  in  NUM_SET*RAD_W  packed radii
- busy  out  1  scan in progress
- table_we  out  1  table write strobe
- table_addr  out  2*COORD_W  {y-1, x-1}
- table_data  out  1  coverage bit
- done  out  1  one-cycle pulse, coincident with the final write
- cover_cnt  out  2*COORD_W+1  covered-point count (only with COVER_COUNT_EN)

## Operation
- States: IDLE → SCAN → FLUSH → IDLE.
  - IDLE: when `start` = 1, capture mode, set_en, centres and radii into internal registers, clear the point counter, and go to SCAN.
  - SCAN: the point counter advances by 1 per cycle, x fastest. When it reaches 2^(2*COORD_W)-1, go to FLUSH.
  - FLUSH: lasts 2 cycles to drain the pipeline, then go to IDLE.
- Per-channel hit: dx = |x − cx|, dy = |y − cy|; hit_i = set_en[i] && (dx² + dy² ≤ r²).
  - True squares, no lookup table.
  - dx and dy are COORD_W+1 bits; squares are 2*COORD_W+2 bits; the sum is 2*COORD_W+3 bits; r² is 2*RAD_W bits.
  - Compare both sides zero-extended to the wider width.
- Combine:
  - Union = OR of hits.
  - Intersection = AND of hits over enabled channels. If no channel is enabled, the result is 0.
  - Exactly-one = popcount(hits) == 1.
- Captured configuration is frozen while busy. Input changes during a scan have no effect. `start` while busy is ignored, not queued.
- Reset values: busy, table_we, table_data, done = 0; table_addr = 0; cover_cnt = 0; state = IDLE.
- `rst_n` asserted mid-scan: immediate return to IDLE with all outputs at reset values. No done pulse is produced. The partial table contents are undefined to the consumer.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: busy = 1; point 0 enters stage 1 (differences and squares registered).
- Stage 2 registers the compare/combine result and drives the outputs.
- Point k is written in cycle k+3: table_we = 1, table_addr = k, table_data valid in that same cycle.
- table_we is continuous for 2^(2*COORD_W) cycles, with no gaps.
- done is high in cycle 2^(2*COORD_W)+2, together with the last write. busy falls in the following cycle, and a new `start` is accepted there.
- Latency from start to done: 2^(2*COORD_W)+2 cycles (66 at the defaults).

## Configuration
- COVER_COUNT_EN defined:
  - cover_cnt counts written points with table_data = 1.
  - It clears when `start` is accepted and is final in the cycle after done.
  - It holds its value until the next accepted `start`.
- COVER_COUNT_EN undefined: the cover_cnt port and counter are absent. All other behaviour is identical.

## Structure
- Package `cover_pkg`: mode encodings (MODE_UNION, MODE_AND, MODE_XOR1), FSM state enum, and the FLUSH depth constant (2).
- Sub-module `cover_dist`: one circle channel containing the pipelined |d|, square, sum and compare. It is instantiated NUM_SET times by generate. Combine logic, counters and FSM stay in `cover_scan`.

## Test plan
All scenarios use default parameters.
- Channel 0 at (4,4), r = 0, channel 1 disabled, union → only addr 27 has data 1; cover_cnt = 1; done in cycle 66.
- Channel 0 at (4,4), r = 1, union → addrs 19, 26, 27, 28, 35 set; cover_cnt = 5.
- Channel 0 at (4,4), r = 1; channel 1 at (5,4), r = 1; mode 1 → addrs 27 and 28 only; cover_cnt = 2. The same setup in mode 2 → cover_cnt = 6.
- Radius 15, union → all 64 points set. With all set_en = 0, intersection → all 0, cover_cnt = 0.
- `start` re-pulsed in cycle 20 with different centres → ignored: output identical to the first scan, exactly one done.
- rst_n low in cycle 30 → outputs return to 0 asynchronously with no done. A subsequent `start` completes a full 64-write scan.
